// File: rtl/sprite_draw.sv
// 64x64 animated sprite compositor: latches position per frame, addresses the frame ROM, overlays onto bg_rgb with 3-clock latency.
// Optional horizontal mirroring (extra "mirror" input) is built when SPRITE_MIRROR_EN is defined.
module sprite_draw #(
    parameter int          NUM_FRAMES      = 11,
    parameter int          TICKS_PER_FRAME = 6,
    parameter logic [11:0] TRANSPARENT     = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        anim_en,
`ifdef SPRITE_MIRROR_EN
    input  logic        mirror,
`endif
    input  logic [11:0] bg_rgb,
    output logic [5:0]  rom_col,
    output logic [5:0]  rom_row,
    input  logic [11:0] rom_color,
    output logic [3:0]  frame_sel,
    output logic [11:0] rgb_out,
    output logic        video_on_out
);

    localparam int          PIPE_STAGES = 2;
    localparam logic [3:0]  LAST_FRAME  = 4'(NUM_FRAMES - 1);
    localparam logic [7:0]  LAST_TICK   = 8'(TICKS_PER_FRAME - 1);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } anim_state_t;

    logic [9:0]  pos_x_reg;
    logic [9:0]  pos_y_reg;
    logic [5:0]  dx;
    logic [5:0]  dy;
    logic        in_box;
    logic [5:0]  col_next;
    logic [5:0]  rom_col_reg;
    logic [5:0]  rom_row_reg;
    logic [11:0] rgb_reg;
    logic        video_on_reg;
    anim_state_t state_reg;
    logic [7:0]  tick_cnt_reg;
    logic [3:0]  frame_sel_reg;

    // Position only moves during vertical blank so a frame never shows a torn sprite.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_x_reg <= '0;
            pos_y_reg <= '0;
        end else if (frame_tick) begin
            pos_x_reg <= sprite_x;
            pos_y_reg <= sprite_y;
        end
    end

    // Only the low six bits of the offset address the ROM.
    assign dx = pixel_x[5:0] - pos_x_reg[5:0];
    assign dy = pixel_y[5:0] - pos_y_reg[5:0];

    // 11-bit right/bottom edges so a sprite near 1023 clips instead of wrapping to column 0.
    assign in_box = ({1'b0, pixel_x} >= {1'b0, pos_x_reg}) &&
                    ({1'b0, pixel_x} <  ({1'b0, pos_x_reg} + 11'd64)) &&
                    ({1'b0, pixel_y} >= {1'b0, pos_y_reg}) &&
                    ({1'b0, pixel_y} <  ({1'b0, pos_y_reg} + 11'd64));

`ifdef SPRITE_MIRROR_EN
    logic mirror_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mirror_reg <= 1'b0;
        end else if (frame_tick) begin
            mirror_reg <= mirror;
        end
    end

    assign col_next = mirror_reg ? ~dx : dx;
`else
    assign col_next = dx;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rom_col_reg <= '0;
            rom_row_reg <= '0;
        end else begin
            rom_col_reg <= col_next;
            rom_row_reg <= dy;
        end
    end

    // Side-band {in_box, video_on, bg_rgb} travels alongside the ROM address and ROM read.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_pipe
            logic [13:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= {in_box, video_on, bg_rgb};
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_pipe[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    logic [13:0] side_d;
    assign side_d = g_pipe[PIPE_STAGES-1].stage_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb_reg      <= '0;
            video_on_reg <= 1'b0;
        end else begin
            video_on_reg <= side_d[12];
            if (!side_d[12]) begin
                rgb_reg <= '0;
            end else if (side_d[13] && (rom_color != TRANSPARENT)) begin
                rgb_reg <= rom_color;
            end else begin
                rgb_reg <= side_d[11:0];
            end
        end
    end

    // Dropping anim_en wins over a simultaneous wrapping frame_tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= HOLD;
            tick_cnt_reg  <= '0;
            frame_sel_reg <= '0;
        end else begin
            case (state_reg)
                HOLD: begin
                    tick_cnt_reg <= '0;
                    if (anim_en) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!anim_en) begin
                        state_reg    <= HOLD;
                        tick_cnt_reg <= '0;
                    end else if (frame_tick) begin
                        if (tick_cnt_reg == LAST_TICK) begin
                            tick_cnt_reg  <= '0;
                            frame_sel_reg <= (frame_sel_reg == LAST_FRAME) ? 4'd0 : frame_sel_reg + 4'd1;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 8'd1;
                        end
                    end
                end
                default: state_reg <= HOLD;
            endcase
        end
    end

    assign rom_col      = rom_col_reg;
    assign rom_row      = rom_row_reg;
    assign frame_sel    = frame_sel_reg;
    assign rgb_out      = rgb_reg;
    assign video_on_out = video_on_reg;

endmodule

// File: doc/sprite_draw.md
SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 11, number of animation frames (frame indices 0..NUM_FRAMES-1).
REQ-002 SHALL have parameter TICKS_PER_FRAME, default 6, frame_tick pulses per animation step.
REQ-003 SHALL have parameter TRANSPARENT, default 12'hFFF, sprite-ROM colour treated as see-through.
REQ-004 Ports (name, direction, width, meaning):
  clk  in  1  sole clock
  reset_n  in  1  reset; synchronous, active-low
  pixel_x  in  10  current scan column
  pixel_y  in  10  current scan row
  video_on  in  1  active-display flag for pixel_x/pixel_y
  frame_tick  in  1  one-cycle pulse at start of vertical blank
  sprite_x  in  10  requested sprite left edge
  sprite_y  in  10  requested sprite top edge
  anim_en  in  1  animation advance enable
  bg_rgb  in  12  background colour for pixel_x/pixel_y
  rom_col  out  6  sprite ROM column address
  rom_row  out  6  sprite ROM row address
  rom_color  in  12  sprite ROM data, valid one clock after rom_col/rom_row
  frame_sel  out  4  selects which frame ROM drives rom_color
  rgb_out  out  12  composited pixel colour
  video_on_out  out  1  video_on aligned with rgb_out

Function
REQ-005 Sprite box SHALL be 64x64; sprite position SHALL be sampled from sprite_x/sprite_y into internal registers only in cycles where frame_tick=1.
REQ-006 in_box SHALL be true when latched_x <= pixel_x < latched_x+64 and latched_y <= pixel_y < latched_y+64, with +64 computed in 11 bits (no wrap; a box past column 1023 is clipped).
REQ-007 rom_col/rom_row SHALL be registered (pixel - latched position)[5:0], updated every cycle; outside the box the value is don't-care but deterministic.
REQ-008 in_box, video_on and bg_rgb SHALL be delayed so that rgb_out and video_on_out update exactly 3 clocks after the corresponding pixel inputs.
REQ-009 Output stage: video_on delayed=0 -> rgb_out=0; else in_box delayed=1 and rom_color!=TRANSPARENT -> rgb_out=rom_color; else rgb_out=bg_rgb delayed.
REQ-010 Animation FSM states: HOLD (anim_en=0) and RUN (anim_en=1); the transition is evaluated every cycle.
REQ-011 In HOLD, tick_cnt SHALL clear to 0 and frame_sel SHALL hold its value.
REQ-012 In RUN, on frame_tick: if tick_cnt==TICKS_PER_FRAME-1 then tick_cnt<=0 and frame_sel advances, else tick_cnt increments.
REQ-013 frame_sel SHALL wrap from NUM_FRAMES-1 to 0 and SHALL change only in cycles with frame_tick=1, so no mid-frame tearing.
REQ-014 When anim_en falls in the same cycle as a wrapping frame_tick, HOLD SHALL take priority: no advance, tick_cnt<=0.

Reset
REQ-015 When reset_n=0 at a clk edge: rgb_out=0, video_on_out=0, rom_col=0, rom_row=0, frame_sel=0, tick_cnt=0, latched position=0, all delay-pipeline flags=0.
REQ-016 Reset asserted mid-line SHALL flush the pipeline; video_on_out SHALL stay 0 for at least 3 clocks after reset_n returns to 1.

Configuration
REQ-017 Macro SPRITE_MIRROR_EN defined: an extra 1-bit input port "mirror" exists, is latched on frame_tick with the position, and when latched=1 rom_col=63-(pixel_x-latched_x)[5:0].
REQ-018 SPRITE_MIRROR_EN undefined: no mirror port; rom_col is never flipped; all other behaviour identical.

Verification
REQ-019 sprite_x=100, sprite_y=50 latched by frame_tick; pixel (100,50) with video_on=1 -> rom_col=0, rom_row=0 after 1 clk; rgb_out=rom_color after 3 clks.
REQ-020 ROM returns 12'hFFF inside box, bg_rgb=12'h0A0 -> rgb_out=12'h0A0; pixel (164,50) -> outside box -> bg_rgb.
REQ-021 anim_en=1, 66 frame_tick pulses -> frame_sel steps every 6 ticks, 0..10, back to 0 on the 66th tick; anim_en=0 mid-count -> frame_sel frozen, tick_cnt=0.
REQ-022 Change sprite_x mid-frame without frame_tick -> rom_col unchanged until next frame_tick.
REQ-023 reset_n=0 mid-line with frame_sel=7 -> next clk all outputs 0, frame_sel=0; video_on_out=0 for 3 clks after release.
REQ-024 (SPRITE_MIRROR_EN) mirror=1 latched, pixel (100,50), sprite_x=100 -> rom_col=63.
